// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shared constants, op/state encodings and the legality check (SHIFT_ROTATE_EN enables ROL/ROR)
package shift_sequencer_pkg;
  localparam int XLEN = 32;
  localparam int SHW = 5;
  localparam logic [2:0] SH_SLL = 3'd0;
  localparam logic [2:0] SH_SRL = 3'd1;
  localparam logic [2:0] SH_SRA = 3'd2;
  localparam logic [2:0] SH_ROL = 3'd3;
  localparam logic [2:0] SH_ROR = 3'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_PASS1, ST_PASS2, ST_DONE} state_t;
  function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
    return op <= SH_ROR;
`else
    return op <= SH_SRA;
`endif
  endfunction
endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result handshake bundle for the shift sequencer
interface shift_sequencer_if;
  import shift_sequencer_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [2:0] in_op;
  logic [XLEN-1:0] in_data;
  logic [XLEN-1:0] in_amt;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_data;
  logic out_err;
  logic busy;
  modport slave (
    input in_valid, in_op, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_err, busy
  );
  modport master (
    output in_valid, in_op, in_data, in_amt, out_ready,
    input in_ready, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/shift_sequencer_barrel.sv
// shift_sequencer_barrel: combinational barrel shifter; left shifts fill 0, right shifts fill feedinbit
module shift_sequencer_barrel
  import shift_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [SHW-1:0]  amt,
  input  logic            dir,
  input  logic            feedinbit,
  output logic [XLEN-1:0] result
);
  always_comb result = dir ? data << amt : XLEN'({{XLEN{feedinbit}}, data} >> amt);
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: issue/retire stage around one time-shared barrel shifter; SHIFT_ROTATE_EN adds two-pass ROL/ROR
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input logic clk,
  input logic rst,
  shift_sequencer_if.slave bus
);
  state_t state, state_n;
  logic [2:0] op_q;
  logic [XLEN-1:0] data_q, amt_q, sh_out, result;
  logic [SHW-1:0] sh_amt;
  logic sh_dir, sh_fill, accept, legal, rot, sat, load;
`ifdef SHIFT_ROTATE_EN
  logic [XLEN-1:0] partial_q;
`endif
  assign bus.in_ready = state == ST_IDLE || (state == ST_DONE && bus.out_ready);
  assign bus.out_valid = state == ST_DONE;
  assign bus.busy = state != ST_IDLE;
  assign accept = bus.in_valid && bus.in_ready;
  assign legal = op_legal(op_q);
  assign rot = op_q == SH_ROL || op_q == SH_ROR;
  assign sat = |amt_q[XLEN-1:SHW];
  shift_sequencer_barrel u_barrel (
    .data(data_q),
    .amt(sh_amt),
    .dir(sh_dir),
    .feedinbit(sh_fill),
    .result(sh_out)
  );
  always_comb begin
    sh_amt = amt_q[SHW-1:0];
    sh_dir = op_q == SH_SLL || op_q == SH_ROL;
    sh_fill = op_q == SH_SRA && data_q[XLEN-1];
    result = !legal ? '0 : (sat && !rot) ? {XLEN{sh_fill}} : sh_out;
`ifdef SHIFT_ROTATE_EN
    // second rotate pass is the complementary logical shift by 32-n, ORed onto pass one
    if (state == ST_PASS2) begin
      sh_amt = -amt_q[SHW-1:0];
      sh_dir = op_q == SH_ROR;
      sh_fill = 1'b0;
      result = partial_q | sh_out;
    end
`endif
    load = 1'b0;
    state_n = state;
    case (state)
      ST_IDLE: state_n = accept ? ST_PASS1 : ST_IDLE;
      ST_PASS1: begin
        load = 1'b1;
        state_n = ST_DONE;
`ifdef SHIFT_ROTATE_EN
        if (legal && rot && |amt_q[SHW-1:0]) begin
          load = 1'b0;
          state_n = ST_PASS2;
        end
`endif
      end
`ifdef SHIFT_ROTATE_EN
      ST_PASS2: begin
        load = 1'b1;
        state_n = ST_DONE;
      end
`endif
      ST_DONE: state_n = !bus.out_ready ? ST_DONE : bus.in_valid ? ST_PASS1 : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      op_q <= '0;
      data_q <= '0;
      amt_q <= '0;
      bus.out_data <= '0;
      bus.out_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= bus.in_op;
        data_q <= bus.in_data;
        amt_q <= bus.in_amt;
      end
      if (load) begin
        bus.out_data <= result;
        bus.out_err <= !legal;
      end
    end
  end
`ifdef SHIFT_ROTATE_EN
  always_ff @(posedge clk) begin
    if (!rst) partial_q <= '0;
    else if (state == ST_PASS1) partial_q <= sh_out;
  end
`endif
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized bench against a transaction-level shift model (SHIFT_ROTATE_EN selects rotate support)
module tb_shift_sequencer;
`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  shift_sequencer_if bus();
  shift_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit pending = 1'b0;
  bit started = 1'b0;
  bit acc_next = 1'b0;
  int cyc = 0;
  int vcyc = 0;
  logic [31:0] exp_data = '0;
  logic exp_err = 1'b0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {err, result} straight from the op definitions
  function automatic logic [32:0] ref_res(input logic [2:0] op, input logic [31:0] d, input logic [31:0] a);
    logic [63:0] dd;
    dd = {d, d};
    case (op)
      3'd0: return {1'b0, d << a};
      3'd1: return {1'b0, d >> a};
      3'd2: return {1'b0, 32'($signed(d) >>> a)};
      3'd3: begin
        dd = dd << a[4:0];
        return ROT ? {1'b0, dd[63:32]} : 33'h1_0000_0000;
      end
      3'd4: begin
        dd = dd >> a[4:0];
        return ROT ? {1'b0, dd[31:0]} : 33'h1_0000_0000;
      end
      default: return 33'h1_0000_0000;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a);
    return (ROT && (op == 3'd3 || op == 3'd4) && a[4:0] != 5'd0) ? 2 : 1;
  endfunction

  // compare DUT against the model, then predict the coming edge
  initial forever begin
    bit vexp, rdy;
    logic [32:0] r;
    @(negedge clk);
    vexp = pending && cyc >= vcyc;
    rdy = !pending || (vexp && bus.out_ready);
    if (started) begin
      chk("out_valid", {32'd0, bus.out_valid}, {32'd0, vexp});
      chk("in_ready", {32'd0, bus.in_ready}, {32'd0, rdy});
      chk("busy", {32'd0, bus.busy}, {32'd0, pending});
      if (vexp) begin
        chk("out_data", {1'b0, bus.out_data}, {1'b0, exp_data});
        chk("out_err", {32'd0, bus.out_err}, {32'd0, exp_err});
      end
    end
    acc_next = rst && bus.in_valid && rdy;
    if (!rst) begin
      pending = 1'b0;
      started = 1'b1;
    end else begin
      if (vexp && bus.out_ready) pending = 1'b0;
      if (acc_next) begin
        r = ref_res(bus.in_op, bus.in_data, bus.in_amt);
        exp_err = r[32];
        exp_data = r[31:0];
        vcyc = cyc + 1 + ref_lat(bus.in_op, bus.in_amt);
        pending = 1'b1;
      end
    end
    cyc++;
  end

  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [31:0] a, input bit rnd, output int waited);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_data = d;
    bus.in_amt = a;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      if (rnd) bus.out_ready = $urandom_range(0, 3) != 0;
      if (acc_next) begin
        bus.in_valid = 1'b0;
        waited = i;
        return;
      end
    end
    bus.in_valid = 1'b0;
    waited = 99;
    chk("send_timeout", 33'd1, 33'd0);
  endtask

  task automatic idle(input int k, input bit rnd);
    repeat (k) begin
      @(posedge clk);
      #1;
      if (rnd) bus.out_ready = $urandom_range(0, 3) != 0;
    end
  endtask

  initial begin
    int w;
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_data = '0;
    bus.in_amt = '0;
    bus.out_ready = 1'b1;
    chk("model_sll", ref_res(3'd0, 32'h0000_00F1, 32'd4), 33'h0_0000_0F10);
    chk("model_sra_sat", ref_res(3'd2, 32'h8000_0000, 32'd33), 33'h0_FFFF_FFFF);
    chk("model_srl_sat", ref_res(3'd1, 32'h8000_0000, 32'd33), 33'h0_0000_0000);
    chk("model_rol", ref_res(3'd3, 32'h8000_0001, 32'd4), ROT ? 33'h0_0000_0018 : 33'h1_0000_0000);
    chk("model_rol_n0", ref_res(3'd3, 32'h8000_0001, 32'd32), ROT ? 33'h0_8000_0001 : 33'h1_0000_0000);
    chk("model_ill", ref_res(3'd7, 32'h1234_5678, 32'd1), 33'h1_0000_0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", {1'b0, bus.out_data}, 33'd0);
    chk("rst_out_err", {32'd0, bus.out_err}, 33'd0);
    chk("rst_out_valid", {32'd0, bus.out_valid}, 33'd0);
    chk("rst_busy", {32'd0, bus.busy}, 33'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {32'd0, bus.in_ready}, 33'd1);
    send(3'd0, 32'h0000_00F1, 32'd4, 0, w);
    send(3'd2, 32'h8000_0000, 32'd33, 0, w);
    send(3'd1, 32'h8000_0000, 32'd33, 0, w);
    send(3'd3, 32'h8000_0001, 32'd4, 0, w);
    send(3'd3, 32'h8000_0001, 32'd32, 0, w);
    send(3'd7, 32'hDEAD_BEEF, 32'd3, 0, w);
    send(3'd3, 32'hDEAD_BEEF, 32'd0, 0, w);
    send(3'd4, 32'h0000_0001, 32'd1, 0, w);
    idle(3, 0);
    bus.out_ready = 1'b0;
    send(3'd0, 32'h1234_5678, 32'd8, 0, w);
    idle(4, 0);
    bus.out_ready = 1'b1;
    send(3'd1, 32'hF000_0000, 32'd4, 0, w);
    chk("b2b_accept_cycles", w, 33'd1);
    idle(3, 0);
    bus.out_ready = 1'b0;
    send(3'd4, 32'h1234_5678, 32'd5, 0, w);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", {32'd0, bus.out_valid}, 33'd0);
    chk("midrst_busy", {32'd0, bus.busy}, 33'd0);
    chk("midrst_in_ready", {32'd0, bus.in_ready}, 33'd1);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    idle(4, 0);
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      logic [31:0] a;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 31);
        1: a = 32 + $urandom_range(0, 31);
        2: a = $urandom;
        default: a = $urandom_range(0, 2);
      endcase
      send(op, $urandom, a, 1, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1);
    end
    bus.out_ready = 1'b1;
    idle(5, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Issue/retire stage wrapped around the ALU's combinational 32-bit barrel shifter.
- Accepts shift requests over a valid/ready handshake and decodes each op into the shifter's direction, shift amount and fill-bit controls.
- Sequences one or two passes through a single shifter instance and holds the result in an output register until the downstream writeback stage takes it.

Parameters:
- XLEN, 32, datapath width; fixed at 32 because the shifter is 32-bit.
- SHW, 5, shift-amount field width, log2(XLEN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request.
- in_op  in  3  0=SLL, 1=SRL, 2=SRA, 3=ROL, 4=ROR.
- in_data  in  32  operand to shift.
- in_amt  in  32  shift amount (register-sourced; full width is checked).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  shift result.
- out_err  out  1  op was illegal; qualified by out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-low. Port names are clk and rst; rst=0 at a clk edge resets the block.
- Reset state: IDLE. Reset values: out_valid=0, out_data=0, out_err=0, busy=0. in_ready=1 once rst deasserts.
- Reset asserted mid-operation discards any in-flight request, even while out_valid=1 and the result is untaken.
- FSM states: IDLE, PASS1, PASS2, DONE.
- Accept: a request is accepted when in_valid && in_ready. On accept, in_op, in_data and in_amt are registered.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back issue with no bubble.
- SLL/SRL/SRA (single pass):
  - Accept at edge T, go to PASS1. The shifter is driven from the registered operands. Result is loaded at edge T+1 and the FSM goes to DONE, so out_valid=1 in cycle T+1.
  - dir = 1 for SLL, 0 otherwise.
  - feedinbit = data[31] for SRA, 0 otherwise.
- Saturation: if amt[31:5] != 0, no shift is performed. Result is 0 for SLL/SRL and {32{data[31]}} for SRA. Latency is unchanged.
- ROL/ROR (two passes, n = amt[4:0]; upper bits are ignored, i.e. mod 32):
  - PASS1 computes x<<n for ROL or x>>n for ROR and stores it in a partial register.
  - PASS2 computes x>>(32-n) for ROL or x<<(32-n) for ROR, as a logical shift.
  - The result is partial | pass2, loaded at edge T+2; out_valid is asserted in cycle T+2.
  - n==0: PASS2 is skipped, result = x, latency 1.
- Illegal op (5-7, or 3-4 when rotates are compiled out): result is 0 with out_err=1 and latency 1. No shifter pass is used.
- DONE: out_valid=1 and out_data/out_err are held stable until out_ready.
  - out_ready=1 with no new accept: go to IDLE.
  - Retire and accept in the same cycle: go straight to PASS1 with the new request.
- in_valid while not ready: the request is ignored. The upstream stage must hold it.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined: ROL/ROR are supported, the PASS2 state and partial register exist, and worst-case latency is 2.
- Undefined: ops 3-4 are illegal (out_err=1, result 0). PASS2 and the partial register are not built. Latency is always 1.

Decomposition:
- Shared package/header holds:
  - op encodings: SH_SLL=3'd0, SH_SRL=3'd1, SH_SRA=3'd2, SH_ROL=3'd3, SH_ROR=3'd4;
  - FSM state encodings;
  - XLEN/SHW constants.
- One sub-module: the existing BarrelShifter, instantiated exactly once and time-shared between PASS1 and PASS2.
- Decode is a small combinational block inside this module and does not need its own sub-module.

Test Plan:
- SLL: data=0x0000_00F1, amt=4, out_ready=1 -> out_valid one cycle after accept; out_data=0x0000_0F10, out_err=0.
- SRA with saturation: data=0x8000_0000, amt=33 -> 0xFFFF_FFFF. SRL with the same inputs -> 0x0000_0000.
- ROL (SHIFT_ROTATE_EN defined): data=0x8000_0001, amt=4 -> 0x0000_0018 two cycles after accept. amt=32 (n=0) -> 0x8000_0001 after one cycle.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> out_data stable and in_ready=0. Then set out_ready=1 with in_valid=1 -> new request accepted in the same cycle, no bubble.
- Illegal op 7 (and op 3 with the macro undefined) -> out_err=1, out_data=0, latency 1.
- Reset: rst=0 in PASS2 of a ROR -> next cycle out_valid=0, busy=0, in_ready=1, and no result is ever emitted.
